// File: rtl/dpsram_port_arb_if.sv
// Request/grant/read-return bundle for one master of the dual-port RAM arbiter.
// The arbiter takes the slave side. A bus adapter or testbench takes the master side.
interface dpsram_port_arb_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 20
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dpsram_port_arb.sv
// Round-robin arbiter for RAM port A, shared by two masters.
// After reset, an optional sequencer zero-fills the whole array before any access is granted.
module dpsram_port_arb #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 20,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                CLK,
    input  logic                RESETN,
    dpsram_port_arb_if.slave    m0,
    dpsram_port_arb_if.slave    m1,
    output logic [ADDR_W-1:0]   RAM_ADDR,
    output logic [DATA_W-1:0]   RAM_DIN,
    output logic                RAM_WEN,
    input  logic [DATA_W-1:0]   RAM_DOUT,
    output logic                INIT_DONE
);

    localparam logic [0:0] ST_CLEAR    = 1'b0;
    localparam logic [0:0] ST_RUN      = 1'b1;
    localparam logic [0:0] RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_addr;
    logic              rr_last;   // 0 = M0 won last, 1 = M1 won last
    logic              rd_pend;
    logic              rd_id;
    logic              run;
    logic              gnt0;
    logic              gnt1;

    // RESETN enters the combinational path so that the RAM is never written while reset is held.
    assign run  = RESETN && (state == ST_RUN);
    assign gnt0 = run && m0.req && (!m1.req || rr_last);
    assign gnt1 = run && m1.req && (!m0.req || !rr_last);

    always_comb begin
        // NOTE: default every output first so that every path assigns it and no latch is inferred.
        RAM_ADDR = '0;
        RAM_DIN  = '0;
        RAM_WEN  = 1'b0;
        if (RESETN && state == ST_CLEAR) begin
            RAM_ADDR = clr_addr;
            RAM_WEN  = 1'b1;
        end else if (gnt0) begin
            RAM_ADDR = m0.addr;
            RAM_DIN  = m0.wdata;
            RAM_WEN  = m0.we;
        end else if (gnt1) begin
            RAM_ADDR = m1.addr;
            RAM_DIN  = m1.wdata;
            RAM_WEN  = m1.we;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= RESET_STATE;
            clr_addr <= '0;
            rr_last  <= 1'b1;
            rd_pend  <= 1'b0;
            rd_id    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every register sees pre-edge values.
            if (state == ST_CLEAR) begin
                clr_addr <= clr_addr + ADDR_W'(1);
                if (clr_addr == LAST_ADDR) state <= ST_RUN;
            end
            rd_pend <= (gnt0 && !m0.we) || (gnt1 && !m1.we);
            if (gnt0 || gnt1) begin
                rr_last <= gnt1;
                rd_id   <= gnt1;
            end
        end
    end

    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign m0.rvalid = rd_pend && !rd_id;
    assign m1.rvalid = rd_pend && rd_id;
    assign m0.rdata  = RAM_DOUT;
    assign m1.rdata  = RAM_DOUT;
    assign INIT_DONE = (state == ST_RUN);

endmodule

// File: doc/dpsram_port_arb.md
Name: dpsram_port_arb

Overview:
- Round-robin arbiter and initialisation sequencer for one port of the 1024x20 dual-port LSRAM.
- Two masters (M0, M1) share the port through a req/gnt handshake. Read data returns one cycle after the grant.
- After reset, the block optionally zero-fills the whole array before granting any access.
- Sits between the Mi-V-side bus adapters and RAM port A; port B is untouched.

Parameters:
- ADDR_W, 10, RAM word-address width (depth = 2**ADDR_W).
- DATA_W, 20, RAM data width.
- CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = go straight to RUN.

Ports:
- CLK  in  1  single system clock, also the RAM clock.
- RESETN  in  1  asynchronous, active-low reset.
- M0_REQ  in  1  M0 access request; held until granted.
- M0_WE  in  1  1 = write, 0 = read; qualified by M0_REQ.
- M0_ADDR  in  ADDR_W  M0 word address.
- M0_WDATA  in  DATA_W  M0 write data.
- M0_GNT  out  1  the M0 request is accepted this cycle.
- M0_RVALID  out  1  M0_RDATA valid; one cycle after a granted M0 read.
- M0_RDATA  out  DATA_W  read data, equal to RAM_DOUT.
- M1_REQ, M1_WE, M1_ADDR, M1_WDATA, M1_GNT, M1_RVALID, M1_RDATA: same as M0.
- RAM_ADDR  out  ADDR_W  to RAM A_ADDR.
- RAM_DIN  out  DATA_W  to RAM A_DIN.
- RAM_WEN  out  1  to RAM A_WEN.
- RAM_DOUT  in  DATA_W  from RAM A_DOUT; valid the cycle after the address edge.
- INIT_DONE  out  1  high once the block is in RUN.

Behaviour:
- Reset (RESETN low, asynchronous): state = CLEAR if CLEAR_ON_RESET, else RUN.
  - clr_addr = 0; rr_last = 1, so M0 has priority first; rd_pend = 0.
  - INIT_DONE = 0 if CLEAR_ON_RESET, else 1.
  - M0_GNT = M1_GNT = 0, M0_RVALID = M1_RVALID = 0.
  - RAM_WEN, RAM_ADDR and RAM_DIN are forced to 0 while RESETN is low.
- State CLEAR:
  - Each cycle: RAM_ADDR = clr_addr, RAM_DIN = 0, RAM_WEN = 1; clr_addr increments.
  - Both GNT outputs are 0; requests stay pending.
  - The cycle that writes address 2**ADDR_W-1 is the last CLEAR cycle. State then moves to RUN and INIT_DONE rises the next cycle, so CLEAR lasts exactly 1024 cycles.
  - Reset during CLEAR restarts the clear at address 0.
- State RUN, arbitration (combinational within the cycle):
  - Only M0_REQ: grant M0. Only M1_REQ: grant M1.
  - Both requesting: grant the master that is not rr_last.
  - rr_last updates to the granted master on the clock edge.
  - Exactly one GNT, or none, per cycle. GNT is a function of REQ and rr_last only, with no dependence on GNT.
- RAM drive in RUN:
  - RAM_ADDR, RAM_DIN and RAM_WEN come from the granted master.
  - RAM_WEN = granted WE.
  - With no grant: RAM_WEN = 0, RAM_ADDR = 0, RAM_DIN = 0.
  - A transfer completes on the edge where REQ & GNT are both high. Back-to-back transfers every cycle are allowed, with no bubble.
- Read return:
  - A granted read registers rd_pend = 1 and rd_id = granted master.
  - Next cycle: Mx_RVALID = 1 for x = rd_id only, and Mx_RDATA = RAM_DOUT.
  - RVALID lasts one cycle unless another read is granted in the same cycle. Reads pipeline at one per cycle.
- Writes produce no RVALID.
- Write then read to the same address in consecutive cycles returns the new data.
- The arbiter detects no same-cycle hazards, because only one access per cycle reaches the port.
- Port B collisions are the system integrator's responsibility.
- Reset mid-read: a pending RVALID is dropped and never asserted.
- Mx_RDATA is not gated. Consumers must qualify it with RVALID.

Test Plan:
- CLEAR_ON_RESET=1, release reset, M0_REQ=1 read addr 5:
  - RAM_WEN=1 for exactly 1024 cycles, addresses 0..1023 with data 0.
  - INIT_DONE rises on cycle 1025 and M0_GNT in the same cycle.
  - M0_RVALID the next cycle with RDATA=0.
- RUN, M0 writes 0xABCDE to addr 0x3FF, then reads 0x3FF:
  - M0_RVALID one cycle after the read grant, RDATA=0xABCDE.
  - M1_RVALID stays 0.
- Both REQ held high for 6 cycles, reads to addresses 1 (M0) and 2 (M1):
  - Grants alternate M0,M1,M0,M1,M0,M1.
  - RVALID alternates with the same pattern, offset by one cycle, with the matching data.
- M1 alone requests for 3 cycles, then both request:
  - M1 is granted three times.
  - The first contended grant goes to M0 (rr_last=M1).
- Assert RESETN low while M1's read is pending and midway through CLEAR (clr_addr=500):
  - No RVALID is asserted.
  - After release, CLEAR restarts at address 0.
- CLEAR_ON_RESET=0:
  - INIT_DONE=1 immediately after reset.
  - The first request is granted in the first cycle after release.
